// File: rtl/vending_pkg.sv
// Shared types and width helpers for the multi-slot vending credit FSM.
// Optional idle auto-refund is enabled by defining VENDING_TIMEOUT_EN.
package vending_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_CREDIT   = 2'd1,
        ST_DISPENSE = 2'd2,
        ST_CHANGE   = 2'd3
    } state_e;

    localparam logic [1:0] ERR_NONE     = 2'd0;
    localparam logic [1:0] ERR_FUNDS    = 2'd1;
    localparam logic [1:0] ERR_SOLD_OUT = 2'd2;

    function automatic int item_w(input int num_items);
        return (num_items <= 2) ? 1 : $clog2(num_items);
    endfunction

    function automatic int credit_w(input int max_credit);
        return $clog2(max_credit + 1);
    endfunction

endpackage

// File: rtl/vending_stock_bank.sv
// Per-slot stock counters with bulk restock, indexed decrement and a
// registered sold-out vector that tracks the counters on the same edge.
module vending_stock_bank #(
    parameter int NUM_ITEMS  = 4,
    parameter int STOCK_INIT = 2,
    parameter int ITEM_W     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 restock,
    input  logic                 dec_en,
    input  logic [ITEM_W-1:0]    dec_idx,
    output logic [NUM_ITEMS-1:0] sold_out
);

    localparam int STOCK_W = $clog2(STOCK_INIT + 1);

    logic [STOCK_W-1:0]   stock_q [NUM_ITEMS];
    logic [STOCK_W-1:0]   stock_d [NUM_ITEMS];
    logic [NUM_ITEMS-1:0] sold_out_q;
    logic [NUM_ITEMS-1:0] sold_out_d;

    always_comb begin
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            stock_d[i] = stock_q[i];
            if (restock) begin
                stock_d[i] = STOCK_W'(STOCK_INIT);
            end else if (dec_en && (ITEM_W'(i) == dec_idx) && (stock_q[i] != '0)) begin
                stock_d[i] = stock_q[i] - 1'b1;
            end
        end
        sold_out_d = '0;
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            sold_out_d[i] = (stock_d[i] == '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= STOCK_W'(STOCK_INIT);
            end
            sold_out_q <= '0;
        end else begin
            for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
                stock_q[i] <= stock_d[i];
            end
            sold_out_q <= sold_out_d;
        end
    end

    assign sold_out = sold_out_q;

endmodule

// File: rtl/vending_machine_credit_fsm.sv
// Multi-coin credit vending FSM with per-slot stock, change and refund.
// Define VENDING_TIMEOUT_EN to auto-refund after TIMEOUT_CYCLES idle cycles in CREDIT.
module vending_machine_credit_fsm
    import vending_pkg::*;
#(
    parameter int NUM_ITEMS      = 4,
    parameter int PRICE          = 15,
    parameter int MAX_CREDIT     = 50,
    parameter int COIN_W         = 6,
    parameter int STOCK_INIT     = 2,
    parameter int TIMEOUT_CYCLES = 100,
    localparam int ITEM_W        = item_w(NUM_ITEMS),
    localparam int CREDIT_W      = credit_w(MAX_CREDIT)
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 coin_valid,
    input  logic [COIN_W-1:0]    coin_value,
    input  logic                 sel_valid,
    input  logic [ITEM_W-1:0]    sel_item,
    input  logic                 cancel,
    input  logic                 restock,
    output logic                 dispense_valid,
    output logic [ITEM_W-1:0]    dispense_item,
    output logic                 change_valid,
    output logic [CREDIT_W-1:0]  change_amount,
    output logic                 coin_reject,
    output logic                 err_sold_out,
    output logic                 err_funds,
    output logic [CREDIT_W-1:0]  credit,
    output logic [NUM_ITEMS-1:0] sold_out
);

    localparam int SUM_W = ((CREDIT_W > COIN_W) ? CREDIT_W : COIN_W) + 1;

    state_e               state_q, state_d;
    logic [CREDIT_W-1:0]  credit_q, credit_d;
    logic                 dispense_valid_q, dispense_valid_d;
    logic [ITEM_W-1:0]    dispense_item_q, dispense_item_d;
    logic                 change_valid_q, change_valid_d;
    logic [CREDIT_W-1:0]  change_amount_q, change_amount_d;
    logic                 coin_reject_q, coin_reject_d;
    logic                 err_sold_out_q, err_sold_out_d;
    logic                 err_funds_q, err_funds_d;
    logic [1:0]           err_code;

    logic [SUM_W-1:0]     coin_sum;
    logic                 coin_ok_idle;
    logic                 coin_fits;
    logic                 slot_empty;
    logic                 sel_bad_slot;
    logic                 sel_low_funds;
    logic                 sel_accept;
    logic                 refund_now;
    logic                 timeout;
    logic                 stock_dec;
    logic [NUM_ITEMS-1:0] stock_empty;

    vending_stock_bank #(
        .NUM_ITEMS  (NUM_ITEMS),
        .STOCK_INIT (STOCK_INIT),
        .ITEM_W     (ITEM_W)
    ) u_stock (
        .clk      (clk),
        .reset    (reset),
        .restock  (restock && (state_q == ST_IDLE)),
        .dec_en   (stock_dec),
        .dec_idx  (dispense_item_q),
        .sold_out (stock_empty)
    );

`ifdef VENDING_TIMEOUT_EN
    localparam int TMO_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;
    logic             idle_in_credit;

    always_comb begin
        idle_in_credit = (state_q == ST_CREDIT) && !(coin_valid || sel_valid || cancel);
        timeout        = idle_in_credit && (tmo_cnt_q == TMO_W'(TIMEOUT_CYCLES - 1));
        tmo_cnt_d      = '0;
        if (idle_in_credit && !timeout) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tmo_cnt_q <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    // Input decode shared by the next-state and output processes.
    always_comb begin
        coin_sum     = SUM_W'(credit_q) + SUM_W'(coin_value);
        coin_ok_idle = (coin_value != '0) && (SUM_W'(coin_value) <= SUM_W'(MAX_CREDIT));
        coin_fits    = (coin_value != '0) && (coin_sum <= SUM_W'(MAX_CREDIT));
        slot_empty   = 1'b1;
        for (int unsigned i = 0; i < NUM_ITEMS; i++) begin
            if (ITEM_W'(i) == sel_item) begin
                slot_empty = stock_empty[i];
            end
        end
        refund_now    = cancel || timeout;
        sel_bad_slot  = sel_valid && slot_empty;
        sel_low_funds = sel_valid && !slot_empty && (credit_q < CREDIT_W'(PRICE));
        sel_accept    = sel_valid && !sel_bad_slot && !sel_low_funds;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= ST_IDLE;
            credit_q         <= '0;
            dispense_valid_q <= 1'b0;
            dispense_item_q  <= '0;
            change_valid_q   <= 1'b0;
            change_amount_q  <= '0;
            coin_reject_q    <= 1'b0;
            err_sold_out_q   <= 1'b0;
            err_funds_q      <= 1'b0;
        end else begin
            state_q          <= state_d;
            credit_q         <= credit_d;
            dispense_valid_q <= dispense_valid_d;
            dispense_item_q  <= dispense_item_d;
            change_valid_q   <= change_valid_d;
            change_amount_q  <= change_amount_d;
            coin_reject_q    <= coin_reject_d;
            err_sold_out_q   <= err_sold_out_d;
            err_funds_q      <= err_funds_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        credit_d  = credit_q;
        stock_dec = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (coin_valid && coin_ok_idle) begin
                    credit_d = CREDIT_W'(coin_value);
                    state_d  = ST_CREDIT;
                end
            end
            ST_CREDIT: begin
                if (refund_now) begin
                    state_d = ST_CHANGE;
                end else if (sel_accept) begin
                    state_d = ST_DISPENSE;
                end else if (coin_valid && coin_fits) begin
                    credit_d = CREDIT_W'(coin_sum);
                end
            end
            ST_DISPENSE: begin
                stock_dec = 1'b1;
                credit_d  = credit_q - CREDIT_W'(PRICE);
                state_d   = (credit_d != '0) ? ST_CHANGE : ST_IDLE;
            end
            ST_CHANGE: begin
                credit_d = '0;
                state_d  = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Pulses are computed one state early so that they land registered in the
    // cycle the FSM occupies the corresponding state.
    always_comb begin
        dispense_valid_d = 1'b0;
        dispense_item_d  = dispense_item_q;
        change_valid_d   = 1'b0;
        change_amount_d  = change_amount_q;
        coin_reject_d    = 1'b0;
        err_code         = ERR_NONE;
        case (state_q)
            ST_IDLE: begin
                if (sel_valid) begin
                    err_code = ERR_FUNDS;
                end
                coin_reject_d = coin_valid && !coin_ok_idle;
            end
            ST_CREDIT: begin
                if (refund_now) begin
                    change_valid_d  = 1'b1;
                    change_amount_d = credit_q;
                    coin_reject_d   = coin_valid;
                end else if (sel_accept) begin
                    dispense_valid_d = 1'b1;
                    dispense_item_d  = sel_item;
                    coin_reject_d    = coin_valid;
                end else begin
                    if (sel_bad_slot) begin
                        err_code = ERR_SOLD_OUT;
                    end else if (sel_low_funds) begin
                        err_code = ERR_FUNDS;
                    end
                    coin_reject_d = coin_valid && !coin_fits;
                end
            end
            ST_DISPENSE: begin
                coin_reject_d = coin_valid;
                if (credit_q != CREDIT_W'(PRICE)) begin
                    change_valid_d  = 1'b1;
                    change_amount_d = credit_q - CREDIT_W'(PRICE);
                end
            end
            ST_CHANGE: begin
                coin_reject_d = coin_valid;
            end
            default: ;
        endcase
        err_funds_d    = (err_code == ERR_FUNDS);
        err_sold_out_d = (err_code == ERR_SOLD_OUT);
    end

    assign dispense_valid = dispense_valid_q;
    assign dispense_item  = dispense_item_q;
    assign change_valid   = change_valid_q;
    assign change_amount  = change_amount_q;
    assign coin_reject    = coin_reject_q;
    assign err_sold_out   = err_sold_out_q;
    assign err_funds      = err_funds_q;
    assign credit         = credit_q;
    assign sold_out       = stock_empty;

endmodule
